// File: rtl/tattr_dma_ctrl.sv
// tattr_dma_ctrl: bus-mastering copy engine that fills the video unit's
// tile-attribute RAM from system memory.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   reg_addr/reg_wdata/reg_wenable CPU register window (0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS)
//   reg_rdata                      combinational read of the selected register
//   vblank                         vertical blanking from the video unit
//   mem_req/mem_addr               memory read request and byte address
//   mem_rdata/mem_ready            memory read data and completion
//   tattr_addr/wdata/wenable       tattr RAM write port
//   busy                           high whenever the engine is not idle
//   irq                            completion pulse (only with TATTR_DMA_IRQ_EN)
//
// Optional feature macro: TATTR_DMA_IRQ_EN adds the irq output and CTRL/STATUS bit3 irq_en.
module tattr_dma_ctrl #(
  parameter int unsigned SRC_WIDTH = 32,
  parameter int unsigned DST_WIDTH = 9,
  parameter int unsigned LEN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  input  logic                 reg_wenable,
  output logic [31:0]          reg_rdata,
  input  logic                 vblank,
  output logic                 mem_req,
  output logic [SRC_WIDTH-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ready,
  output logic [DST_WIDTH-1:0] tattr_addr,
  output logic [7:0]           tattr_wdata,
  output logic                 tattr_wenable,
  output logic                 busy
`ifdef TATTR_DMA_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VBL,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state;
  logic [SRC_WIDTH-1:0] src;
  logic [DST_WIDTH-1:0] dst;
  logic [LEN_WIDTH-1:0] len;
  logic                 wait_vbl;
  logic                 done;
  logic                 abort_pend;
  logic                 irq_en_bit;

  logic ctrl_wr;
  logic start_req;
  logic abort_req;

  // Decode of CTRL writes
  assign ctrl_wr   = reg_wenable && (reg_addr == REG_CTRL);
  assign start_req = ctrl_wr && reg_wdata[0];
  assign abort_req = ctrl_wr && reg_wdata[2];

`ifdef TATTR_DMA_IRQ_EN
  logic irq_en;
  assign irq_en_bit = irq_en;
`else
  assign irq_en_bit = 1'b0;
`endif

  // Register read mux; counters are returned live
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_SRC:  reg_rdata = 32'(src);
      REG_DST:  reg_rdata = 32'(dst);
      REG_LEN:  reg_rdata = 32'(len);
      default:  reg_rdata = {28'd0, irq_en_bit, wait_vbl, done, busy};
    endcase
  end

  // Register window, transfer counters and sequencing FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      src           <= '0;
      dst           <= '0;
      len           <= '0;
      wait_vbl      <= 1'b0;
      done          <= 1'b0;
      abort_pend    <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      tattr_addr    <= '0;
      tattr_wdata   <= '0;
      tattr_wenable <= 1'b0;
`ifdef TATTR_DMA_IRQ_EN
      irq_en        <= 1'b0;
      irq           <= 1'b0;
`endif
    end else begin
      tattr_wenable <= 1'b0;
`ifdef TATTR_DMA_IRQ_EN
      irq           <= 1'b0;
`endif

      // Address/length registers are frozen while a transfer owns them
      if (reg_wenable && !busy) begin
        case (reg_addr)
          REG_SRC: src <= SRC_WIDTH'(reg_wdata);
          REG_DST: dst <= DST_WIDTH'(reg_wdata);
          REG_LEN: len <= LEN_WIDTH'(reg_wdata);
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        wait_vbl <= reg_wdata[1];
        done     <= 1'b0;
`ifdef TATTR_DMA_IRQ_EN
        irq_en   <= reg_wdata[3];
`endif
      end

      case (state)
        S_IDLE: begin
          // Abort in the same write as start wins
          if (start_req && !abort_req) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= S_DONE;
            end else if (reg_wdata[1]) begin
              state <= S_WAIT_VBL;
            end else begin
              state    <= S_READ;
              mem_req  <= 1'b1;
              mem_addr <= src;
            end
          end
        end

        S_WAIT_VBL: begin
          if (abort_req) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (vblank) begin
            state    <= S_READ;
            mem_req  <= 1'b1;
            mem_addr <= src;
          end
        end

        S_READ: begin
          // An abort here must still let the outstanding read complete
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (abort_req || abort_pend) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              abort_pend <= 1'b0;
            end else begin
              tattr_wdata   <= mem_rdata;
              tattr_addr    <= dst;
              tattr_wenable <= 1'b1;
              state         <= S_WRITE;
            end
          end else if (abort_req) begin
            abort_pend <= 1'b1;
          end
        end

        S_WRITE: begin
          src <= src + SRC_WIDTH'(1);
          dst <= dst + DST_WIDTH'(1);
          len <= len - LEN_WIDTH'(1);
          if (abort_req) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (len == LEN_WIDTH'(1)) begin
            state <= S_DONE;
          end else if (wait_vbl && !vblank) begin
            state <= S_WAIT_VBL;
          end else begin
            state    <= S_READ;
            mem_req  <= 1'b1;
            mem_addr <= src + SRC_WIDTH'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
          busy  <= 1'b0;
`ifdef TATTR_DMA_IRQ_EN
          irq   <= irq_en;
`endif
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
